// File: rtl/rx_frame_parser.sv
// XGMII receive frame parser: byte-accurate frame tracking, header field
// extraction (DA/SA/VLAN/length-type), FCS capture and per-frame status.
module rx_frame_parser #(
  parameter int LANES    = 8,
  parameter int MAX_TAGS = 2,
  parameter int MIN_LEN  = 64,
  parameter int MAX_LEN  = 1518
) (
  input  logic               rxclk,
  input  logic               reset,
  input  logic [8*LANES-1:0] rxd,
  input  logic [LANES-1:0]   rxc,
  output logic               in_frame,
  output logic               sof,
  output logic               frame_done,
  output logic [15:0]        frame_len,
  output logic [47:0]        da,
  output logic [47:0]        sa,
  output logic [15:0]        lt,
  output logic [1:0]         vlan_cnt,
  output logic [15:0]        vlan_tci,
  output logic               pause_frame,
  output logic [31:0]        fcs,
  output logic               len_error,
  output logic               short_error,
  output logic               long_error,
  output logic               code_error
);
  typedef enum logic {IDLE, DATA} state_t;

  localparam logic [1:0]       MT   = 2'(MAX_TAGS);
  localparam logic [LANES-1:0] C0   = {1'b1, {(LANES-1){1'b0}}};
  localparam logic [16:0]      LMAX = 17'(MAX_LEN);
  localparam logic [15:0]      LMIN = 16'(MIN_LEN);
  localparam bit               L8   = (LANES == 8);

  state_t      r_state, w_nstate;
  logic        r_pre, r_t0, r_ltd, r_cerr;
  logic [15:0] r_cnt, r_slot, r_lt, r_tci;
  logic [47:0] r_da, r_sa;
  logic [31:0] r_fcs;
  logic [7:0]  r_hi;
  logic [1:0]  r_k, r_vcnt;

  logic [7:0]  w_b [LANES];
  logic [LANES-1:0] w_c;
  logic        w_pre1, w_pre2, w_sw, w_hit, w_accept, w_done;
  logic        w_t0, w_ltd, w_cerr;
  logic [15:0] w_cnt, w_slot, w_lt, w_tci;
  logic [47:0] w_da, w_sa;
  logic [31:0] w_fcs;
  logic [7:0]  w_hi;
  logic [1:0]  w_k, w_vcnt;
  logic [16:0] w_vx4;
  logic signed [16:0] w_pay, w_min;
  logic        w_lerr, w_serr, w_gerr, w_pause;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_b[l] = rxd[8*(LANES-l)-1 -: 8];
      w_c[l] = rxc[LANES-1-l];
    end
  end

  // pre1: start word (LANES=8) or first preamble word (LANES=4)
  always_comb begin
    w_pre1 = (rxc == C0) && (w_b[0] == 8'hFB);
    w_pre2 = (rxc == '0);
    for (int l = 0; l < LANES; l++) begin
      if (l > 0 && w_b[l] != ((L8 && l == LANES-1) ? 8'hD5 : 8'h55))
        w_pre1 = 1'b0;
      if (w_b[l] != ((l == LANES-1) ? 8'hD5 : 8'h55))
        w_pre2 = 1'b0;
    end
    w_sw = L8 ? w_pre1 : (r_pre && w_pre2);
  end

  always_comb begin
    w_cnt  = r_cnt;
    w_slot = r_slot;
    w_lt   = r_lt;
    w_tci  = r_tci;
    w_da   = r_da;
    w_sa   = r_sa;
    w_fcs  = r_fcs;
    w_hi   = r_hi;
    w_k    = r_k;
    w_vcnt = r_vcnt;
    w_t0   = r_t0;
    w_ltd  = r_ltd;
    w_cerr = r_cerr;
    w_hit  = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (!w_hit && !w_pre1) begin
        if (w_c[l] && w_b[l] == 8'hFD) begin
          w_hit = 1'b1;
        end else begin
          if (w_c[l]) w_cerr = 1'b1;
          if (w_cnt < 16'd6) w_da = {w_da[39:0], w_b[l]};
          else if (w_cnt < 16'd12) w_sa = {w_sa[39:0], w_b[l]};
          if (!w_ltd && w_cnt == w_slot) w_hi = w_b[l];
          if (!w_ltd && w_cnt == w_slot + 16'd1) begin
            if (({w_hi, w_b[l]} == 16'h8100 ||
                 {w_hi, w_b[l]} == 16'h88A8) && w_k < MT) begin
              w_t0   = w_t0 | (w_k == 2'd0);
              w_vcnt = w_vcnt + 2'd1;
              w_k    = w_k + 2'd1;
              w_slot = w_slot + 16'd4;
            end else begin
              w_lt  = {w_hi, w_b[l]};
              w_ltd = 1'b1;
            end
          end
          // outermost TCI always sits at bytes 14..15
          if (w_t0 && w_cnt == 16'd14) w_tci[15:8] = w_b[l];
          if (w_t0 && w_cnt == 16'd15) w_tci[7:0] = w_b[l];
          w_fcs = {w_fcs[23:0], w_b[l]};
          if (w_cnt != 16'hFFFF) w_cnt = w_cnt + 16'd1;
        end
      end
    end
    w_vx4   = {13'd0, w_vcnt, 2'b00};
    w_pay   = $signed({1'b0, w_cnt}) - 17'sd18 - $signed(w_vx4);
    w_min   = (w_lt < 16'd46) ? 17'sd46 : $signed({1'b0, w_lt});
    w_lerr  = (w_lt <= 16'd1500) && (w_pay < 17'sd0 || w_pay != w_min);
    w_serr  = w_cnt < LMIN;
    w_gerr  = {1'b0, w_cnt} > LMAX + w_vx4;
    w_pause = (w_lt == 16'h8808) && (w_da == 48'h0180C2000001);
  end

  always_comb begin
    w_nstate = r_state;
    w_accept = 1'b0;
    w_done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_sw) begin
          w_nstate = DATA;
          w_accept = 1'b1;
        end
      end
      DATA: begin
        w_done   = w_hit || w_pre1;
        w_accept = w_pre1 && L8;
        if (w_hit || (w_pre1 && !L8)) w_nstate = IDLE;
      end
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge rxclk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pre   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_pre   <= !L8 && w_pre1;
    end
  end

  always_ff @(posedge rxclk) begin
    if (!reset || w_accept) begin
      r_cnt  <= '0;
      r_slot <= 16'd12;
      r_lt   <= '0;
      r_tci  <= '0;
      r_da   <= '0;
      r_sa   <= '0;
      r_fcs  <= '0;
      r_hi   <= '0;
      r_k    <= '0;
      r_vcnt <= '0;
      r_t0   <= 1'b0;
      r_ltd  <= 1'b0;
      r_cerr <= 1'b0;
    end else if (r_state == DATA) begin
      r_cnt  <= w_cnt;
      r_slot <= w_slot;
      r_lt   <= w_lt;
      r_tci  <= w_tci;
      r_da   <= w_da;
      r_sa   <= w_sa;
      r_fcs  <= w_fcs;
      r_hi   <= w_hi;
      r_k    <= w_k;
      r_vcnt <= w_vcnt;
      r_t0   <= w_t0;
      r_ltd  <= w_ltd;
      r_cerr <= w_cerr;
    end
  end

  always_ff @(posedge rxclk) begin
    if (!reset) begin
      in_frame    <= 1'b0;
      sof         <= 1'b0;
      frame_done  <= 1'b0;
      frame_len   <= '0;
      da          <= '0;
      sa          <= '0;
      lt          <= '0;
      vlan_cnt    <= '0;
      vlan_tci    <= '0;
      pause_frame <= 1'b0;
      fcs         <= '0;
      len_error   <= 1'b0;
      short_error <= 1'b0;
      long_error  <= 1'b0;
      code_error  <= 1'b0;
    end else begin
      sof        <= w_accept;
      frame_done <= w_done;
      in_frame   <= (r_state == DATA) && !w_done;
      // an aborting start word reports the old frame, then restarts
      if (w_done) begin
        frame_len   <= w_cnt;
        da          <= w_da;
        sa          <= w_sa;
        lt          <= w_lt;
        vlan_cnt    <= w_vcnt;
        vlan_tci    <= w_tci;
        pause_frame <= w_pause;
        fcs         <= w_fcs;
        len_error   <= w_lerr;
        short_error <= w_serr;
        long_error  <= w_gerr;
        code_error  <= w_cerr | w_pre1;
      end else if (w_accept) begin
        frame_len   <= '0;
        da          <= '0;
        sa          <= '0;
        lt          <= '0;
        vlan_cnt    <= '0;
        vlan_tci    <= '0;
        pause_frame <= 1'b0;
        fcs         <= '0;
        len_error   <= 1'b0;
        short_error <= 1'b0;
        long_error  <= 1'b0;
        code_error  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rx_frame_parser.sv
// Directed bench for rx_frame_parser: an 8-lane/2-tag and a
// 4-lane/1-tag instance driven with hand-built frames.
module tb_rx_frame_parser;
  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [63:0] d8 = {8{8'h07}};
  logic [7:0]  c8 = 8'hFF;
  logic [31:0] d4 = {4{8'h07}};
  logic [3:0]  c4 = 4'hF;
  int total = 0;
  int bad = 0;

  logic f8_in, f8_sof, f8_done, f8_pause, f8_le, f8_se, f8_ge, f8_ce;
  logic [15:0] f8_len, f8_lt, f8_tci;
  logic [47:0] f8_da, f8_sa;
  logic [1:0]  f8_vc;
  logic [31:0] f8_fcs;
  logic f4_in, f4_sof, f4_done, f4_pause, f4_le, f4_se, f4_ge, f4_ce;
  logic [15:0] f4_len, f4_lt, f4_tci;
  logic [47:0] f4_da, f4_sa;
  logic [1:0]  f4_vc;
  logic [31:0] f4_fcs;

  always #5 clk = ~clk;

  rx_frame_parser #(.LANES(8), .MAX_TAGS(2)) u8 (
    .rxclk(clk), .reset(rst_n), .rxd(d8), .rxc(c8),
    .in_frame(f8_in), .sof(f8_sof), .frame_done(f8_done),
    .frame_len(f8_len), .da(f8_da), .sa(f8_sa), .lt(f8_lt),
    .vlan_cnt(f8_vc), .vlan_tci(f8_tci), .pause_frame(f8_pause),
    .fcs(f8_fcs), .len_error(f8_le), .short_error(f8_se),
    .long_error(f8_ge), .code_error(f8_ce)
  );

  rx_frame_parser #(.LANES(4), .MAX_TAGS(1)) u4 (
    .rxclk(clk), .reset(rst_n), .rxd(d4), .rxc(c4),
    .in_frame(f4_in), .sof(f4_sof), .frame_done(f4_done),
    .frame_len(f4_len), .da(f4_da), .sa(f4_sa), .lt(f4_lt),
    .vlan_cnt(f4_vc), .vlan_tci(f4_tci), .pause_frame(f4_pause),
    .fcs(f4_fcs), .len_error(f4_le), .short_error(f4_se),
    .long_error(f4_ge), .code_error(f4_ce)
  );

  function automatic bq_t mk(input logic [47:0] fda, input logic [47:0] fsa,
                             input int ntag, input logic [15:0] t0,
                             input logic [15:0] t1, input logic [15:0] flt,
                             input int tot, input logic [31:0] ff);
    bq_t q;
    int pay;
    for (int i = 5; i >= 0; i--) q.push_back(fda[8*i +: 8]);
    for (int i = 5; i >= 0; i--) q.push_back(fsa[8*i +: 8]);
    if (ntag == 2) begin
      q.push_back(8'h88); q.push_back(8'hA8);
      q.push_back(t0[15:8]); q.push_back(t0[7:0]);
      q.push_back(8'h81); q.push_back(8'h00);
      q.push_back(t1[15:8]); q.push_back(t1[7:0]);
    end else if (ntag == 1) begin
      q.push_back(8'h81); q.push_back(8'h00);
      q.push_back(t0[15:8]); q.push_back(t0[7:0]);
    end
    q.push_back(flt[15:8]); q.push_back(flt[7:0]);
    pay = tot - 18 - 4 * ntag;
    for (int i = 0; i < pay; i++) q.push_back(8'(i + 1));
    for (int i = 3; i >= 0; i--) q.push_back(ff[8*i +: 8]);
    return q;
  endfunction

  task automatic drive8(input logic [63:0] d, input logic [7:0] c);
    @(negedge clk); d8 = d; c8 = c;
    @(posedge clk); #1;
  endtask

  task automatic drive4(input logic [31:0] d, input logic [3:0] c);
    @(negedge clk); d4 = d; c4 = c;
    @(posedge clk); #1;
  endtask

  task automatic run8(input bq_t q, input int e_idx, input bit st,
                      output bit s_seen, output bit d_seen);
    int i;
    bit tp;
    i = 0; tp = 1'b0; s_seen = 1'b0;
    if (st) begin
      drive8({8'hFB, {6{8'h55}}, 8'hD5}, 8'h80);
      s_seen = f8_sof;
    end
    while (!tp) begin
      logic [63:0] d;
      logic [7:0] c;
      for (int l = 0; l < 8; l++) begin
        logic [7:0] b;
        logic k;
        if (i < q.size()) begin
          k = (i == e_idx); b = k ? 8'hFE : q[i]; i++;
        end else if (!tp) begin
          b = 8'hFD; k = 1'b1; tp = 1'b1;
        end else begin
          b = 8'h07; k = 1'b1;
        end
        d[63-8*l -: 8] = b; c[7-l] = k;
      end
      drive8(d, c);
    end
    d_seen = f8_done;
    drive8({8{8'h07}}, 8'hFF);
  endtask

  task automatic run4(input bq_t q, output bit s_seen, output bit d_seen);
    int i;
    bit tp;
    i = 0; tp = 1'b0;
    drive4({8'hFB, 8'h55, 8'h55, 8'h55}, 4'h8);
    drive4({8'h55, 8'h55, 8'h55, 8'hD5}, 4'h0);
    s_seen = f4_sof;
    while (!tp) begin
      logic [31:0] d;
      logic [3:0] c;
      for (int l = 0; l < 4; l++) begin
        if (i < q.size()) begin
          d[31-8*l -: 8] = q[i]; c[3-l] = 1'b0; i++;
        end else if (!tp) begin
          d[31-8*l -: 8] = 8'hFD; c[3-l] = 1'b1; tp = 1'b1;
        end else begin
          d[31-8*l -: 8] = 8'h07; c[3-l] = 1'b1;
        end
      end
      drive4(d, c);
    end
    d_seen = f4_done;
    drive4({4{8'h07}}, 4'hF);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if ({f8_in, f8_sof, f8_done, f8_ce} !== 4'b0) begin bad++; $display("FAIL rst_flags8 got %b want 0000", {f8_in, f8_sof, f8_done, f8_ce}); end
    total++; if (f8_len !== 16'd0) begin bad++; $display("FAIL rst_len8 got %0d want 0", f8_len); end
    total++; if (f4_fcs !== 32'd0) begin bad++; $display("FAIL rst_fcs4 got %h want 0", f4_fcs); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_pause();
    bit s, d;
    run8(mk(48'h0180C2000001, 48'h001122334455, 0, 0, 0, 16'h8808, 64, 32'hDEADBEEF), -1, 1'b1, s, d);
    total++; if (s !== 1'b1) begin bad++; $display("FAIL pause_sof got %b want 1", s); end
    total++; if (d !== 1'b1) begin bad++; $display("FAIL pause_done got %b want 1", d); end
    total++; if (f8_len !== 16'd64) begin bad++; $display("FAIL pause_len got %0d want 64", f8_len); end
    total++; if (f8_pause !== 1'b1) begin bad++; $display("FAIL pause_flag got %b want 1", f8_pause); end
    total++; if (f8_da !== 48'h0180C2000001) begin bad++; $display("FAIL pause_da got %h want 0180c2000001", f8_da); end
    total++; if (f8_sa !== 48'h001122334455) begin bad++; $display("FAIL pause_sa got %h want 001122334455", f8_sa); end
    total++; if (f8_lt !== 16'h8808) begin bad++; $display("FAIL pause_lt got %h want 8808", f8_lt); end
    total++; if (f8_fcs !== 32'hDEADBEEF) begin bad++; $display("FAIL pause_fcs got %h want deadbeef", f8_fcs); end
    total++; if ({f8_le, f8_se, f8_ge, f8_ce} !== 4'b0) begin bad++; $display("FAIL pause_err got %b want 0000", {f8_le, f8_se, f8_ge, f8_ce}); end
    total++; if ({f8_in, f8_done, f8_vc} !== 4'b0) begin bad++; $display("FAIL pause_idle got %b want 0000", {f8_in, f8_done, f8_vc}); end
  endtask

  task automatic test_vlan();
    bit s, d;
    run8(mk(48'h0A0B0C0D0E0F, 48'h020000000001, 1, 16'h0064, 0, 16'h002E, 68, 32'h01020304), -1, 1'b1, s, d);
    total++; if (f8_vc !== 2'd1) begin bad++; $display("FAIL vlan_cnt got %0d want 1", f8_vc); end
    total++; if (f8_tci !== 16'h0064) begin bad++; $display("FAIL vlan_tci got %h want 0064", f8_tci); end
    total++; if (f8_lt !== 16'h002E) begin bad++; $display("FAIL vlan_lt got %h want 002e", f8_lt); end
    total++; if ({f8_le, f8_ge, f8_pause} !== 3'b0) begin bad++; $display("FAIL vlan_err got %b want 000", {f8_le, f8_ge, f8_pause}); end
    total++; if (f8_len !== 16'd68) begin bad++; $display("FAIL vlan_len got %0d want 68", f8_len); end
    run8(mk(48'h0A0B0C0D0E0F, 48'h020000000001, 1, 16'h0064, 0, 16'h0800, 1522, 32'h01020304), -1, 1'b1, s, d);
    total++; if (f8_ge !== 1'b0) begin bad++; $display("FAIL vlan_1522_long got %b want 0", f8_ge); end
    total++; if (f8_len !== 16'd1522) begin bad++; $display("FAIL vlan_1522_len got %0d want 1522", f8_len); end
    run8(mk(48'h0A0B0C0D0E0F, 48'h020000000001, 1, 16'h0064, 0, 16'h0800, 1523, 32'h01020304), -1, 1'b1, s, d);
    total++; if (f8_ge !== 1'b1) begin bad++; $display("FAIL vlan_1523_long got %b want 1", f8_ge); end
    run8(mk(48'h0A0B0C0D0E0F, 48'h020000000001, 2, 16'h0005, 16'h0064, 16'h002E, 72, 32'h01020304), -1, 1'b1, s, d);
    total++; if (f8_vc !== 2'd2) begin bad++; $display("FAIL qinq_cnt got %0d want 2", f8_vc); end
    total++; if (f8_tci !== 16'h0005) begin bad++; $display("FAIL qinq_tci got %h want 0005", f8_tci); end
    total++; if ({f8_lt, f8_le} !== {16'h002E, 1'b0}) begin bad++; $display("FAIL qinq_lt got %h/%b want 002e/0", f8_lt, f8_le); end
  endtask

  task automatic test_len();
    bit s, d;
    run8(mk(48'h0A0B0C0D0E0F, 48'h020000000001, 0, 0, 0, 16'h0010, 64, 32'h0), -1, 1'b1, s, d);
    total++; if ({f8_le, f8_se} !== 2'b00) begin bad++; $display("FAIL len_pad got %b want 00", {f8_le, f8_se}); end
    run8(mk(48'h0A0B0C0D0E0F, 48'h020000000001, 0, 0, 0, 16'h0030, 64, 32'h0), -1, 1'b1, s, d);
    total++; if (f8_le !== 1'b1) begin bad++; $display("FAIL len_mismatch got %b want 1", f8_le); end
    run8(mk(48'h0A0B0C0D0E0F, 48'h020000000001, 0, 0, 0, 16'h0800, 60, 32'h0), -1, 1'b1, s, d);
    total++; if ({f8_se, f8_le} !== 2'b10) begin bad++; $display("FAIL len_short got %b want 10", {f8_se, f8_le}); end
    total++; if (f8_len !== 16'd60) begin bad++; $display("FAIL len_short_len got %0d want 60", f8_len); end
  endtask

  task automatic test_code();
    bit s, d;
    bq_t q;
    q = mk(48'h0A0B0C0D0E0F, 48'h020000000001, 0, 0, 0, 16'h0800, 64, 32'h11223344);
    run8(q, 30, 1'b1, s, d);
    total++; if (f8_ce !== 1'b1) begin bad++; $display("FAIL code_e got %b want 1", f8_ce); end
    total++; if (f8_len !== 16'd64) begin bad++; $display("FAIL code_e_len got %0d want 64", f8_len); end
    drive8({8'hFB, {6{8'h55}}, 8'hD5}, 8'h80);
    for (int w = 0; w < 3; w++) begin
      logic [63:0] dw;
      for (int l = 0; l < 8; l++) dw[63-8*l -: 8] = q[8*w + l];
      drive8(dw, 8'h00);
    end
    drive8({8'hFB, {6{8'h55}}, 8'hD5}, 8'h80);
    total++; if ({f8_done, f8_sof, f8_ce} !== 3'b111) begin bad++; $display("FAIL abort_flags got %b want 111", {f8_done, f8_sof, f8_ce}); end
    total++; if (f8_len !== 16'd24) begin bad++; $display("FAIL abort_len got %0d want 24", f8_len); end
    run8(q, -1, 1'b0, s, d);
    total++; if ({d, f8_ce} !== 2'b10) begin bad++; $display("FAIL abort_next got %b want 10", {d, f8_ce}); end
    total++; if (f8_len !== 16'd64) begin bad++; $display("FAIL abort_next_len got %0d want 64", f8_len); end
  endtask

  task automatic test_lanes4();
    bit s, d, seen;
    bq_t q;
    drive4({8'hFB, 8'h55, 8'h55, 8'h55}, 4'h8);
    drive4({8'h55, 8'h55, 8'h55, 8'h55}, 4'h0);
    total++; if (f4_sof !== 1'b0) begin bad++; $display("FAIL l4_badpre_sof got %b want 0", f4_sof); end
    drive4({4{8'h07}}, 4'hF);
    total++; if (f4_in !== 1'b0) begin bad++; $display("FAIL l4_badpre_in got %b want 0", f4_in); end
    run4(mk(48'h0A0B0C0D0E0F, 48'h020000000001, 2, 16'h0007, 16'h0064, 16'h002E, 64, 32'h0), s, d);
    total++; if ({s, d} !== 2'b11) begin bad++; $display("FAIL l4_tag_pulses got %b want 11", {s, d}); end
    total++; if ({f4_vc, f4_tci} !== {2'd1, 16'h0007}) begin bad++; $display("FAIL l4_tag got %0d/%h want 1/0007", f4_vc, f4_tci); end
    total++; if ({f4_lt, f4_le} !== {16'h8100, 1'b0}) begin bad++; $display("FAIL l4_lt got %h/%b want 8100/0", f4_lt, f4_le); end
    q = mk(48'h0A0B0C0D0E0F, 48'h020000000001, 0, 0, 0, 16'h0800, 66, 32'hA1B2C3D4);
    run4(q, s, d);
    total++; if (f4_fcs !== 32'hA1B2C3D4) begin bad++; $display("FAIL l4_fcs got %h want a1b2c3d4", f4_fcs); end
    total++; if ({d, f4_len} !== {1'b1, 16'd66}) begin bad++; $display("FAIL l4_len got %b/%0d want 1/66", d, f4_len); end
    drive4({8'hFB, 8'h55, 8'h55, 8'h55}, 4'h8);
    drive4({8'h55, 8'h55, 8'h55, 8'hD5}, 4'h0);
    for (int w = 0; w < 3; w++) drive4({q[4*w], q[4*w+1], q[4*w+2], q[4*w+3]}, 4'h0);
    @(negedge clk); rst_n = 1'b0; d4 = {q[12], q[13], q[14], q[15]};
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    #1;
    total++; if ({f4_len, f4_fcs} !== 48'd0) begin bad++; $display("FAIL l4_rst_clr got %h/%h want 0/0", f4_len, f4_fcs); end
    total++; if ({f4_in, f4_da} !== 49'd0) begin bad++; $display("FAIL l4_rst_in got %b/%h want 0/0", f4_in, f4_da); end
    seen = 1'b0;
    drive4({q[16], q[17], q[18], q[19]}, 4'h0);
    seen |= f4_done;
    drive4({8'hFD, 8'h07, 8'h07, 8'h07}, 4'hF);
    seen |= f4_done;
    drive4({4{8'h07}}, 4'hF);
    seen |= f4_done;
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL l4_rst_done got %b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_pause();
    test_vlan();
    test_len();
    test_code();
    test_lanes4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
